seven_segment_scanner: RTL

Time-multiplexed driver for an N-digit common-anode/cathode 7-segment display. It shares one hex-to-segment decoder across all digits and cycles a digit-enable strobe at a fixed refresh rate, with a ghosting guard band between digits. A new display value is accepted through a valid/ready handshake and applied only at frame boundaries, so a partial value is never shown. It sits between the CPU/debug register file and the board display pins.

---
 rtl/seven_segment_scanner_pkg.sv | 39 +++
 rtl/seven_segment_scanner_decoder.sv | 33 +++
 rtl/seven_segment_scanner.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/seven_segment_scanner_pkg.sv
// rtl/seven_segment_scanner_pkg.sv - shared segment constants, slot states and digit-enable helpers
package seven_segment_scanner_pkg;

    // Segment patterns, bit order {g,f,e,d,c,b,a}, active-high
    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_A     = 7'b1110111;
    localparam logic [6:0] SEG_B     = 7'b1111100;
    localparam logic [6:0] SEG_C     = 7'b0111001;
    localparam logic [6:0] SEG_D     = 7'b1011110;
    localparam logic [6:0] SEG_E     = 7'b1111001;
    localparam logic [6:0] SEG_F     = 7'b1110001;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // Phase within one digit slot
    typedef enum logic {
        SLOT_GUARD = 1'b0,
        SLOT_DRIVE = 1'b1
    } slot_state_e;

    // Level that turns a digit enable on for the given polarity
    function automatic logic an_on(input logic active_low);
        return ~active_low;
    endfunction

    // Level that turns a digit enable off for the given polarity
    function automatic logic an_off(input logic active_low);
        return active_low;
    endfunction

endpackage

// File: rtl/seven_segment_scanner_decoder.sv
// rtl/seven_segment_scanner_decoder.sv - hex nibble to 7-segment decoder
module seven_segment_scanner_decoder
    import seven_segment_scanner_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // Full 16-entry hex lookup
    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seven_segment_scanner.sv
// rtl/seven_segment_scanner.sv - N-digit multiplexed 7-segment scanner; SEVEN_SEG_DECIMAL_POINT_EN adds dp_in/dp
module seven_segment_scanner
    import seven_segment_scanner_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int REFRESH_DIV   = 50000,
    parameter int GUARD_CYCLES  = 500,
    parameter int AN_ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    value_valid,
    output logic                    value_ready,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    input  logic                    lzs_en,
`ifdef SEVEN_SEG_DECIMAL_POINT_EN
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic                    dp,
`endif
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int NW = 4 * NUM_DIGITS;
`ifdef SEVEN_SEG_DECIMAL_POINT_EN
    localparam int PW = NW + NUM_DIGITS;
`else
    localparam int PW = NW;
`endif
    localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] CNT_GUARD = CW'(GUARD_CYCLES);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);
    localparam logic          AN_ON_B   = an_on(AN_ACTIVE_LOW != 0);
    localparam logic          AN_OFF_B  = an_off(AN_ACTIVE_LOW != 0);
    localparam slot_state_e   STATE_RST = (GUARD_CYCLES > 0) ? SLOT_GUARD : SLOT_DRIVE;

    slot_state_e             state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [PW-1:0]           disp_q, disp_d;
    logic [PW-1:0]           pend_q, pend_d;
    logic                    full_q, full_d;
    logic [6:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    frame_done_q, frame_done_d;
    logic [PW-1:0]           offer;
    logic [NW-1:0]           nibbles;
    logic [NUM_DIGITS-1:0]   dp_bits;
    logic [3:0]              nib;
    logic [6:0]              dec_seg;
    logic                    frame_end;
    logic                    suppress;
    logic                    dark;

    // The display word carries the dp bits above the nibbles so both move through one pending/display path
`ifdef SEVEN_SEG_DECIMAL_POINT_EN
    logic dp_q, dp_d;
    assign offer   = {dp_in, value};
    assign dp_bits = disp_q[PW-1:NW];
    assign dp      = dp_q;
`else
    assign offer   = value;
    assign dp_bits = '0;
`endif

    assign nibbles     = disp_q[NW-1:0];
    assign nib         = nibbles[4*idx_q +: 4];
    assign frame_end   = (cnt_q == CNT_LAST) && (idx_q == IDX_LAST);
    assign value_ready = ~full_q;
    assign seg         = seg_q;
    assign an          = an_q;
    assign frame_done  = frame_done_q;

    seven_segment_scanner_decoder u_decoder (
        .bcd (nib),
        .seg (dec_seg)
    );

    // Leading-zero suppression: current digit and everything above it are zero, and no dp asks for it
    assign suppress = lzs_en && (idx_q != '0) && ((nibbles >> {idx_q, 2'b00}) == '0) && !dp_bits[idx_q];
    assign dark     = blank_mask[idx_q] || suppress;

    // Slot/digit counters, next slot phase and the next registered output values
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        idx_d = idx_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
        state_d      = (cnt_d < CNT_GUARD) ? SLOT_GUARD : SLOT_DRIVE;
        frame_done_d = (cnt_d == CNT_LAST) && (idx_d == IDX_LAST);
        seg_d        = SEG_BLANK;
        an_d         = {NUM_DIGITS{AN_OFF_B}};
`ifdef SEVEN_SEG_DECIMAL_POINT_EN
        dp_d         = 1'b0;
`endif
        if (state_q == SLOT_DRIVE && !dark) begin
            seg_d        = dec_seg;
            an_d[idx_q]  = AN_ON_B;
`ifdef SEVEN_SEG_DECIMAL_POINT_EN
            dp_d         = dp_bits[idx_q];
`endif
        end
    end

    // Handshake into pending; pending (or a same-cycle offer) lands in the display only at frame end
    always_comb begin
        pend_d = pend_q;
        full_d = full_q;
        disp_d = disp_q;
        if (value_valid && !full_q) begin
            if (frame_end) begin
                disp_d = offer;
            end else begin
                pend_d = offer;
                full_d = 1'b1;
            end
        end else if (frame_end && full_q) begin
            disp_d = pend_q;
            full_d = 1'b0;
        end
    end

    // Slot phase register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= STATE_RST;
        end else begin
            state_q <= state_d;
        end
    end

    // Counters, value registers and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            disp_q       <= '0;
            pend_q       <= '0;
            full_q       <= 1'b0;
            seg_q        <= SEG_BLANK;
            an_q         <= {NUM_DIGITS{AN_OFF_B}};
            frame_done_q <= 1'b0;
`ifdef SEVEN_SEG_DECIMAL_POINT_EN
            dp_q         <= 1'b0;
`endif
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            disp_q       <= disp_d;
            pend_q       <= pend_d;
            full_q       <= full_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
            frame_done_q <= frame_done_d;
`ifdef SEVEN_SEG_DECIMAL_POINT_EN
            dp_q         <= dp_d;
`endif
        end
    end

endmodule
